// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: access-size encodings, op kinds, FSM states
// and the EX/MEM stage-register layout.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    op_e         op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        regwrite;
  } stage_t;

  // Size 11 behaves as a word, so any size with bit 1 set needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Little-endian lane logic: extracts/extends a load lane from rdata and splices
// the low bits of wdata into the same lane of rdata for sub-word store merges.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] shifted;

  always_comb begin
    shamt     = '0;
    lane_mask = '1;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        shamt     = {addr_lo, 3'b000};
        lane_mask = 32'h0000_00ff;
      end
      SZ_HALF: begin
        shamt     = {addr_lo[1], 4'b0000};
        lane_mask = 32'h0000_ffff;
      end
      default: begin
        shamt     = '0;
        lane_mask = '1;
      end
    endcase

    shifted = rdata >> shamt;
    case (size)
      SZ_BYTE: load_data = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase

    merge_data = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM register plus load/store unit in front of a word-addressed DataMemory
// (combinational read, synchronous write); sub-word stores use a 2-cycle RMW.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int width      = 32,
  parameter int wordLength = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_load,
  input  logic                     ex_store,
  input  logic [1:0]               ex_size,
  input  logic                     ex_unsigned,
  input  logic [31:0]              ex_addr,
  input  logic [wordLength-1:0]    ex_wdata,
  input  logic [4:0]               ex_rd,
  input  logic                     ex_regwrite,
  input  logic                     flush,
  output logic                     stall,
  output logic [$clog2(width)-1:0] mem_addr,
  output logic [wordLength-1:0]    mem_wdata,
  output logic                     mem_write,
  input  logic [wordLength-1:0]    mem_rdata,
  output logic                     wb_valid,
  output logic                     wb_regwrite,
  output logic [4:0]               wb_rd,
  output logic [wordLength-1:0]    wb_data,
  output logic                     wb_misalign,
  output mem_state_e               dbg_state
);

  localparam int AW = $clog2(width);

  stage_t      s_q;
  stage_t      ex_stage;
  mem_state_e  state_q;
  mem_state_e  state_d;
  logic [31:0] merge_q;
  logic [31:0] align_rdata;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        misalign;

  // Handshake: S accepts the EX instruction on every edge where stall is low;
  // EX must hold its inputs while stall is high. flush turns the capture into a bubble.
  always_comb begin
    ex_stage          = '0;
    ex_stage.valid    = ex_valid;
    ex_stage.op       = ex_store ? OP_STORE : (ex_load ? OP_LOAD : OP_ALU);
    ex_stage.size     = ex_size;
    ex_stage.uns      = ex_unsigned;
    ex_stage.addr     = ex_addr;
    ex_stage.wdata    = ex_wdata;
    ex_stage.rd       = ex_rd;
    ex_stage.regwrite = ex_regwrite;
  end

  assign misalign    = s_q.valid && (s_q.op != OP_ALU) && is_misaligned(s_q.size, s_q.addr[1:0]);
  assign mem_addr    = s_q.addr[AW+1:2];
  assign align_rdata = (state_q == MERGE) ? merge_q : mem_rdata;
  assign dbg_state   = state_q;

  mem_load_align u_align (
    .rdata      (align_rdata),
    .wdata      (s_q.wdata),
    .addr_lo    (s_q.addr[1:0]),
    .size       (s_q.size),
    .uns        (s_q.uns),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are forced idle while rst is high so a reset during MERGE drops the write.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (s_q.valid && (s_q.op == OP_STORE) && !misalign) begin
            if (s_q.size[1]) begin
              mem_write = 1'b1;
              mem_wdata = s_q.wdata;
            end else begin
              stall   = 1'b1;
              state_d = MERGE;
            end
          end
        end
        MERGE: begin
          mem_write = 1'b1;
          mem_wdata = merge_data;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      merge_q     <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_misalign <= 1'b0;
    end else begin
      if (stall) merge_q <= mem_rdata;
      if (!stall) s_q <= flush ? '0 : ex_stage;
      // A sub-word store reports to WB only once, when its MERGE cycle completes.
      if (stall) begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
        wb_rd       <= '0;
        wb_data     <= '0;
        wb_misalign <= 1'b0;
      end else begin
        wb_valid    <= s_q.valid;
        wb_regwrite <= s_q.valid && s_q.regwrite && (s_q.op != OP_STORE) && !misalign;
        wb_rd       <= s_q.rd;
        wb_misalign <= misalign;
        if (!s_q.valid || misalign)  wb_data <= '0;
        else if (s_q.op == OP_LOAD)  wb_data <= load_data;
        else if (s_q.op == OP_ALU)   wb_data <= s_q.addr;
        else                         wb_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// traffic scored against a program-order model of memory and write-back.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_unsigned, ex_regwrite, flush;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_write;
  logic        wb_valid, wb_regwrite, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  mem_state_e  dbg_state;

  mem_access_stage #(.width(32), .wordLength(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .flush(flush), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / DataMemory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] dmem [32];
  always @(posedge clk) if (mem_write === 1'b1) dmem[mem_addr] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr];

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];   // {care, regwrite, misalign, rd, data}
  logic [36:0] wexp_q[$];  // {word index, data}
  logic [31:0] model_mem [32];
  logic        chk_en = 1'b0;
  int          stall_cnt = 0, wr_cnt = 0, mis_cnt = 0;
  logic [31:0] last_wb_data = '0;
  logic        last_wb_rw = 1'b0, last_wb_mis = 1'b0;
  logic [4:0]  last_waddr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (program-order semantics) ----------------
  task automatic model_accept(input logic ld, input logic st, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] wd,
                              input logic [4:0] rd, input logic rw);
    int idx, lane;
    logic mis;
    logic [31:0] old, nw, val;
    logic [7:0]  b;
    logic [15:0] h;
    idx  = int'((a >> 2) % 32);
    lane = int'(a[1:0]);
    old  = model_mem[idx];
    mis  = (ld || st) && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0));
    if (mis) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, rd, 32'h0});
    end else if (st) begin
      nw = old;
      if (sz == 2'd0)      nw[8*lane +: 8] = wd[7:0];
      else if (sz == 2'd1) nw[16*(lane/2) +: 16] = wd[15:0];
      else                 nw = wd;
      model_mem[idx] = nw;
      wexp_q.push_back({5'(idx), nw});
      exp_q.push_back({1'b0, 1'b0, 1'b0, rd, 32'h0});
    end else if (ld) begin
      if (sz == 2'd0) begin
        b = old[8*lane +: 8];
        if (un) val = 32'(b); else val = 32'($signed(b));
      end else if (sz == 2'd1) begin
        h = old[16*(lane/2) +: 16];
        if (un) val = 32'(h); else val = 32'($signed(h));
      end else begin
        val = old;
      end
      exp_q.push_back({1'b1, rw, 1'b0, rd, val});
    end else begin
      exp_q.push_back({1'b1, rw, 1'b0, rd, a});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    logic [36:0] w;
    if (chk_en && rst === 1'b0) begin
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(wb_data), 64'hdead_0000);
        end else begin
          e = exp_q.pop_front();
          check("wb_out", {wb_regwrite, wb_misalign, e[39] ? wb_rd : 5'h0, e[39] ? wb_data : 32'h0},
                {e[38], e[37], e[39] ? e[36:32] : 5'h0, e[39] ? e[31:0] : 32'h0});
          last_wb_data = wb_data;
          last_wb_rw   = wb_regwrite;
          last_wb_mis  = wb_misalign;
        end
      end else begin
        check("wb_valid_idle", 64'(wb_valid), 64'h0);
      end
      if (mem_write === 1'b1) begin
        wr_cnt++;
        last_waddr = mem_addr;
        if (wexp_q.size() == 0) begin
          check("write_unexpected", {27'h0, mem_addr, mem_wdata}, 64'hdead_0000);
        end else begin
          w = wexp_q.pop_front();
          check("mem_write", {27'h0, mem_addr, mem_wdata}, {27'h0, w});
        end
      end
      if (stall === 1'b1) stall_cnt++;
      if (wb_misalign === 1'b1) mis_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0; ex_regwrite = 1'b0; flush = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the instruction is captured.
  task automatic issue(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic fl);
    int guard;
    ex_valid = v; ex_load = ld; ex_store = st; ex_size = sz; ex_unsigned = un;
    ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_regwrite = rw; flush = fl;
    guard = 0;
    while (stall === 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check("stall_timeout", 64'(guard), 64'h0);
    if (v && !fl) model_accept(ld, st, sz, un, a, wd, rd, rw);
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, w0, m0;
    logic ld, st;
    logic [31:0] a;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    check("reset_wb", {wb_valid, wb_regwrite, wb_misalign, wb_rd, wb_data}, 64'h0);
    check("reset_mem", {mem_write, mem_addr, mem_wdata}, 64'h0);
    check("reset_stall_state", {stall, dbg_state}, 64'h0);
    chk_en = 1'b1;

    for (int i = 0; i < 32; i++) issue(1, 0, 1, SZ_WORD, 0, 32'(i * 4), $urandom(), 5'd0, 0, 0);
    drain(3);

    // 2: word store then word load
    w0 = wr_cnt;
    issue(1, 0, 1, SZ_WORD, 0, 32'h14, 32'h1122_3344, 5'd1, 0, 0);
    issue(1, 1, 0, SZ_WORD, 0, 32'h14, 32'h0, 5'd3, 1, 0);
    drain(3);
    check("t2_write_count", 64'(wr_cnt - w0), 64'd1);
    check("t2_write_addr", 64'(last_waddr), 64'd5);
    check("t2_load", {last_wb_rw, last_wb_data}, {1'b1, 32'h1122_3344});

    // 3: byte store merge, signed/unsigned byte loads
    s0 = stall_cnt;
    issue(1, 0, 1, SZ_BYTE, 0, 32'h15, 32'h0000_00ab, 5'd0, 0, 0);
    drain(3);
    check("t3_stall_cycles", 64'(stall_cnt - s0), 64'd1);
    check("t3_merged_word", 64'(dmem[5]), 64'h1122_ab44);
    issue(1, 1, 0, SZ_BYTE, 0, 32'h15, 32'h0, 5'd4, 1, 0);
    drain(3);
    check("t3_lb", 64'(last_wb_data), 64'hffff_ffab);
    issue(1, 1, 0, SZ_BYTE, 1, 32'h15, 32'h0, 5'd4, 1, 0);
    drain(3);
    check("t3_lbu", 64'(last_wb_data), 64'h0000_00ab);

    // 4: half loads
    issue(1, 0, 1, SZ_WORD, 0, 32'h14, 32'h8001_0000, 5'd0, 0, 0);
    issue(1, 1, 0, SZ_HALF, 0, 32'h16, 32'h0, 5'd6, 1, 0);
    drain(3);
    check("t4_lh", 64'(last_wb_data), 64'hffff_8001);
    issue(1, 1, 0, SZ_HALF, 1, 32'h16, 32'h0, 5'd6, 1, 0);
    drain(3);
    check("t4_lhu", 64'(last_wb_data), 64'h0000_8001);

    // 5: misaligned half store and word load
    w0 = wr_cnt; m0 = mis_cnt;
    issue(1, 0, 1, SZ_HALF, 0, 32'h13, 32'h0000_beef, 5'd0, 0, 0);
    drain(3);
    check("t5_sh_misalign", {last_wb_mis, last_wb_rw}, 64'b10);
    check("t5_sh_pulse", 64'(mis_cnt - m0), 64'd1);
    issue(1, 1, 0, SZ_WORD, 0, 32'h16, 32'h0, 5'd7, 1, 0);
    drain(3);
    check("t5_lw_misalign", {last_wb_mis, last_wb_rw}, 64'b10);
    check("t5_pulses_writes", {32'(mis_cnt - m0), 32'(wr_cnt - w0)}, {32'd2, 32'd0});

    // 6: reset during MERGE, then flushed word store
    w0 = wr_cnt;
    ex_valid = 1; ex_store = 1; ex_size = SZ_BYTE; ex_addr = 32'h15; ex_wdata = 32'h0000_00ab;
    @(negedge clk);
    check("t6_stall", 64'(stall), 64'd1);
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_write_in_reset", 64'(mem_write), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_state_idle", 64'(dbg_state), 64'(IDLE));
    ex_valid = 1; ex_store = 1; ex_size = SZ_WORD; ex_addr = 32'h14; ex_wdata = 32'hdead_beef; flush = 1;
    @(negedge clk);
    drain(4);
    check("t6_no_writes", 64'(wr_cnt - w0), 64'd0);
    check("t6_mem_unchanged", 64'(dmem[5]), 64'h8001_0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 2);
      ld = (op == 1);
      st = (op == 2);
      if (op == 0) a = $urandom();
      else begin
        a = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) a = a | ($urandom() & 32'hffff_ff80);
      end
      issue($urandom_range(0, 9) != 0, ld, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) drain($urandom_range(1, 2));
    end
    drain(5);

    check("wb_queue_drained", 64'(exp_q.size()), 64'd0);
    check("write_queue_drained", 64'(wexp_q.size()), 64'd0);
    for (int i = 0; i < 32; i++) check("final_mem", 64'(dmem[i]), 64'(model_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
